// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and request legality check for the load/store unit.
package lsu_pkg;

  // RV32I funct3 encodings for memory accesses
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StErr,
    StLdAddr,
    StLdData,
    StSwWr,
    StRmwRd,
    StRmwWr
  } lsu_state_e;

  // True when a request must be rejected: illegal funct3 for its direction, or misaligned
  function automatic logic lsu_is_err(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic legal;
    logic misal;
    if (we) begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    // funct3[1:0] gives the access size for every legal encoding
    misal = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
            ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return !legal || misal;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_rdata,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_load_data,
  output logic [XLEN-1:0] o_store_merged
);

  logic [4:0]      w_sh_b;
  logic [4:0]      w_sh_h;
  logic [XLEN-1:0] w_rd_b;
  logic [XLEN-1:0] w_rd_h;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  assign w_sh_b = {i_addr_lo, 3'b000};
  assign w_sh_h = {i_addr_lo[1], 4'b0000};
  assign w_rd_b = i_rdata >> w_sh_b;
  assign w_rd_h = i_rdata >> w_sh_h;
  assign w_byte = w_rd_b[7:0];
  assign w_half = w_rd_h[15:0];

  // Select the addressed lane and sign- or zero-extend it
  always_comb begin
    o_load_data = i_rdata;
    case (i_funct3)
      F3_B:    o_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_H:    o_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_HU:   o_load_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

  // Replace the addressed byte/half of the read word with store data, keep the rest
  always_comb begin
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] ins;
    if (i_funct3 == F3_H) begin
      mask = {{(XLEN-16){1'b0}}, 16'hFFFF} << w_sh_h;
      ins  = {{(XLEN-16){1'b0}}, i_wdata[15:0]} << w_sh_h;
    end else begin
      mask = {{(XLEN-8){1'b0}}, 8'hFF} << w_sh_b;
      ins  = {{(XLEN-8){1'b0}}, i_wdata[7:0]} << w_sh_b;
    end
    o_store_merged = (i_rdata & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end for a word-only data memory.
// Sub-word stores are done as read-modify-write; bad requests never touch memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              mem_wEn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [XLEN-1:0]   mem_write_data,
  input  logic [XLEN-1:0]   mem_read_data
);

  lsu_state_e        r_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;

  logic [XLEN-1:0]   w_load_data;
  logic [XLEN-1:0]   w_merged;

  lsu_byte_lane #(
    .XLEN(XLEN)
  ) u_byte_lane (
    .i_funct3      (r_funct3),
    .i_addr_lo     (r_addr[1:0]),
    .i_rdata       (mem_read_data),
    .i_wdata       (r_wdata),
    .o_load_data   (w_load_data),
    .o_store_merged(w_merged)
  );

  // Request latch and sequencing FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            // Upper address bits are dropped: the memory only decodes ADDR_W bits
            r_addr   <= req_addr[ADDR_W-1:0];
            r_wdata  <= req_wdata;
            if (lsu_is_err(req_we, req_funct3, req_addr[1:0])) begin
              r_state <= StErr;
            end else if (!req_we) begin
              r_state <= StLdAddr;
            end else if (req_funct3 == F3_W) begin
              r_state <= StSwWr;
            end else begin
              r_state <= StRmwRd;
            end
          end
        end
        StLdAddr: r_state <= StLdData;
        StRmwRd:  r_state <= StRmwWr;
        default:  r_state <= StIdle;
      endcase
    end
  end

  // State-decoded outputs; reset gates strobes so an aborted access never writes
  always_comb begin
    req_ready      = (r_state == StIdle);
    resp_valid     = !rst && ((r_state == StErr) || (r_state == StLdData) ||
                              (r_state == StSwWr) || (r_state == StRmwWr));
    resp_err       = !rst && (r_state == StErr);
    mem_wEn        = !rst && ((r_state == StSwWr) || (r_state == StRmwWr));
    mem_address    = r_addr;
    resp_rdata     = '0;
    mem_write_data = '0;
    if (!rst && (r_state == StLdData) && !r_we) begin
      resp_rdata = w_load_data;
    end
    if (r_state == StSwWr) begin
      mem_write_data = r_wdata;
    end else if (r_state == StRmwWr) begin
      mem_write_data = w_merged;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_wEn;
  logic [15:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  load_store_unit #(
    .ADDR_W(16),
    .XLEN  (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .resp_rdata    (resp_rdata),
    .mem_wEn       (mem_wEn),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: synchronous read, one cycle latency
  logic [31:0] mem [0:16383];
  int          wr_count;
  initial wr_count = 0;
  always @(posedge clk) begin
    if (mem_wEn) begin
      mem[mem_address[15:2]] <= mem_write_data;
      wr_count <= wr_count + 1;
    end
    mem_read_data <= mem[mem_address[15:2]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          lat;
    logic [31:0] exp;   // load result, or word written for a store
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic err, input int lat,
                              input logic [31:0] exp);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.err = err; v.lat = lat; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
  endtask

  // One isolated request: issue, wait (bounded) for the response, check it
  task automatic do_vec(input vec_t v, input string tag);
    int lat;
    int wr0;
    @(negedge clk);
    drive(v);
    req_valid = 1'b1;
    check({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
    wr0 = wr_count;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " resp_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, " latency"}, lat, v.lat);
    check({tag, " resp_err"}, {31'b0, resp_err}, {31'b0, v.err});
    if (v.err) begin
      check({tag, " no write strobe"}, {31'b0, mem_wEn}, 32'd0);
      check({tag, " no write done"}, wr_count, wr0);
    end else if (v.we) begin
      check({tag, " mem_wEn"}, {31'b0, mem_wEn}, 32'd1);
      check({tag, " mem_write_data"}, mem_write_data, v.exp);
      check({tag, " mem_address"}, {16'b0, mem_address}, {16'b0, v.addr[15:0]});
    end else begin
      check({tag, " resp_rdata"}, resp_rdata, v.exp);
      check({tag, " load no write"}, {31'b0, mem_wEn}, 32'd0);
    end
  endtask

  vec_t vecs[18];
  vec_t b2b[10];

  initial begin
    int   wr0;
    int   idx;
    int   nresp;
    int   acc[10];
    logic [31:0] old_word;

    // isolated vectors, applied in order against a shared memory image
    vecs[0]  = mk(1, 3'b010, 32'h0000_0010, 32'h1111_1111, 0, 1, 32'h1111_1111); // SW
    vecs[1]  = mk(0, 3'b010, 32'h0000_0010, 32'h0,         0, 2, 32'h1111_1111); // LW
    vecs[2]  = mk(1, 3'b000, 32'h0000_0013, 32'h0000_00AB, 0, 2, 32'hAB11_1111); // SB
    vecs[3]  = mk(0, 3'b000, 32'h0000_0013, 32'h0,         0, 2, 32'hFFFF_FFAB); // LB
    vecs[4]  = mk(0, 3'b100, 32'h0000_0013, 32'h0,         0, 2, 32'h0000_00AB); // LBU
    vecs[5]  = mk(1, 3'b010, 32'h0000_0010, 32'h1111_1111, 0, 1, 32'h1111_1111); // SW
    vecs[6]  = mk(1, 3'b001, 32'h0000_0012, 32'h0000_8001, 0, 2, 32'h8001_1111); // SH
    vecs[7]  = mk(0, 3'b001, 32'h0000_0012, 32'h0,         0, 2, 32'hFFFF_8001); // LH
    vecs[8]  = mk(0, 3'b101, 32'h0000_0012, 32'h0,         0, 2, 32'h0000_8001); // LHU
    vecs[9]  = mk(0, 3'b001, 32'h0000_0010, 32'h0,         0, 2, 32'h0000_1111); // LH
    vecs[10] = mk(0, 3'b010, 32'h0000_0012, 32'h0,         1, 1, 32'h0);         // LW misal
    vecs[11] = mk(1, 3'b001, 32'h0000_0011, 32'hFFFF_FFFF, 1, 1, 32'h0);         // SH misal
    vecs[12] = mk(0, 3'b011, 32'h0000_0010, 32'h0,         1, 1, 32'h0);         // bad load
    vecs[13] = mk(1, 3'b100, 32'h0000_0010, 32'hFFFF_FFFF, 1, 1, 32'h0);         // bad store
    vecs[14] = mk(0, 3'b010, 32'hFFFF_0010, 32'h0,         0, 2, 32'h8001_1111); // LW wrap
    vecs[15] = mk(1, 3'b000, 32'h0000_0010, 32'h0000_005A, 0, 2, 32'h8001_115A); // SB lane0
    vecs[16] = mk(0, 3'b000, 32'h0000_0011, 32'h0,         0, 2, 32'h0000_0011); // LB
    vecs[17] = mk(0, 3'b000, 32'h0000_0010, 32'h0,         0, 2, 32'h0000_005A); // LB

    b2b[0] = mk(1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 0, 1, 32'h0);
    b2b[1] = mk(0, 3'b010, 32'h0000_0020, 32'h0,         0, 2, 32'hCAFE_F00D);
    b2b[2] = mk(1, 3'b000, 32'h0000_0021, 32'h0000_0000, 0, 2, 32'h0);
    b2b[3] = mk(0, 3'b000, 32'h0000_0021, 32'h0,         0, 2, 32'h0000_0000);
    b2b[4] = mk(1, 3'b001, 32'h0000_0022, 32'h0000_1234, 0, 2, 32'h0);
    b2b[5] = mk(0, 3'b101, 32'h0000_0022, 32'h0,         0, 2, 32'h0000_1234);
    b2b[6] = mk(0, 3'b010, 32'h0000_0021, 32'h0,         1, 1, 32'h0);
    b2b[7] = mk(0, 3'b100, 32'h0000_0023, 32'h0,         0, 2, 32'h0000_0012);
    b2b[8] = mk(1, 3'b111, 32'h0000_0020, 32'h0,         1, 1, 32'h0);
    b2b[9] = mk(0, 3'b010, 32'h0000_0020, 32'h0,         0, 2, 32'h1234_000D);

    // reset
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst mem_wEn gated", {31'b0, mem_wEn}, 32'd0);
    check("rst resp_valid gated", {31'b0, resp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("reset req_ready", {31'b0, req_ready}, 32'd1);
    check("reset resp_err", {31'b0, resp_err}, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset mem_address", {16'b0, mem_address}, 32'd0);
    check("reset mem_write_data", mem_write_data, 32'd0);

    for (int i = 0; i < 18; i++) begin
      do_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // reset during the write cycle of a byte store aborts it
    old_word = mem[4];
    @(negedge clk);
    drive(mk(1, 3'b000, 32'h0000_0010, 32'h0000_0077, 0, 2, 32'h0));
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort in write cycle", {31'b0, mem_wEn}, 32'd1);
    wr0 = wr_count;
    rst = 1'b1;
    #1;
    check("abort mem_wEn", {31'b0, mem_wEn}, 32'd0);
    check("abort resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort req_ready", {31'b0, req_ready}, 32'd1);
    check("abort no write", wr_count, wr0);
    check("abort word kept", mem[4], 32'h8001_115A);
    do_vec(mk(0, 3'b010, 32'h0000_0010, 32'h0, 0, 2, old_word), "abort readback");

    // back-to-back with req_valid held high
    idx = 0;
    nresp = 0;
    for (int cyc = 0; cyc < 100 && nresp < 10; cyc++) begin
      @(negedge clk);
      if (resp_valid) begin
        check($sformatf("b2b%0d latency", nresp), cyc - acc[nresp], b2b[nresp].lat);
        check($sformatf("b2b%0d resp_err", nresp), {31'b0, resp_err}, {31'b0, b2b[nresp].err});
        if (!b2b[nresp].we && !b2b[nresp].err) begin
          check($sformatf("b2b%0d resp_rdata", nresp), resp_rdata, b2b[nresp].exp);
        end
        nresp++;
      end
      if (req_ready) begin
        if (idx < 10) begin
          drive(b2b[idx]);
          req_valid = 1'b1;
          acc[idx] = cyc;
          idx++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b response count", nresp, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
